// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter.
// Sends one command byte to the keyboard over the open-drain PS/2 clock/data
// pair. The host holds the clock low for INHIBIT ticks. It then pulls data low
// as the start bit and releases the clock. The device then clocks out 8 data
// bits (LSB first), odd parity and a stop bit, and acknowledges on the 11th
// falling edge.
//
// Ports
//   clock  system clock (56MHz)
//   reset  synchronous, active-low reset
//   ce     clock enable; all state advances only when ce=1
//   ps2    {data, clock} bus levels (asynchronous)
//   tx     transfer request, sampled on ce while busy=0
//   d      byte to send, captured with tx
//   ckOe   1 = drive ps2 clock low
//   dtOe   1 = drive ps2 data low
//   busy   transfer in progress
//   done   one-ce-tick pulse at end of transfer
//   err    valid with done: 1 = no ack / timeout
//
// Configuration
//   PS2_HOST_TX_WATCHDOG_EN  when defined, a device-clock watchdog aborts a
//                            stalled transfer after TIMEOUT ticks without a
//                            clock fall; otherwise TIMEOUT is unused.
module ps2_host_tx #(
    parameter int INHIBIT = 700,
    parameter int FILTER  = 8,
    parameter int TIMEOUT = 105000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic [1:0] ps2,
    input  logic       tx,
    input  logic [7:0] d,
    output logic       ckOe,
    output logic       dtOe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int IW = (INHIBIT > 1) ? $clog2(INHIBIT) : 1;
    localparam int FW = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT - 1);
    localparam logic [FW-1:0] FLT_LAST = FW'(FILTER - 1);
`ifdef PS2_HOST_TX_WATCHDOG_EN
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INHIBIT  = 3'd1,
        ST_RTS      = 3'd2,
        ST_SEND     = 3'd3,
        ST_WAITIDLE = 3'd4
    } state_t;

    // Odd parity bit for a data byte.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    state_t          state_r, state_s;
    logic [1:0]      sync1_r, sync2_r;
    logic            filt_clk_r;
    logic [FW-1:0]   fcnt_r;
    logic            fall_s;
    logic            data_s;
    logic [7:0]      byte_r, byte_s;
    logic            parity_r, parity_s;
    logic [3:0]      idx_r, idx_s;
    logic [IW-1:0]   icnt_r, icnt_s;
    logic            ck_oe_r, ck_oe_s;
    logic            dt_oe_r, dt_oe_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;
    logic            err_r, err_s;
`ifdef PS2_HOST_TX_WATCHDOG_EN
    logic [WW-1:0]   wd_r, wd_s;
`endif

    // Filtered clock flips on this tick from 1 to 0: a device clock fall.
    assign fall_s = ce & filt_clk_r & ~sync2_r[0] & (fcnt_r == FLT_LAST);
    assign data_s = sync2_r[1];

    // Two-flop synchroniser and clock glitch filter. The idle bus is high.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1_r    <= 2'b11;
            sync2_r    <= 2'b11;
            filt_clk_r <= 1'b1;
            fcnt_r     <= {FW{1'b0}};
        end else if (ce) begin
            sync1_r <= ps2;
            sync2_r <= sync1_r;
            if (sync2_r[0] == filt_clk_r) begin
                fcnt_r <= {FW{1'b0}};
            end else if (fcnt_r == FLT_LAST) begin
                filt_clk_r <= sync2_r[0];
                fcnt_r     <= {FW{1'b0}};
            end else begin
                fcnt_r <= fcnt_r + FW'(1);
            end
        end
    end

    // Transfer state and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            byte_r   <= 8'h00;
            parity_r <= 1'b0;
            idx_r    <= 4'd0;
            icnt_r   <= {IW{1'b0}};
            ck_oe_r  <= 1'b0;
            dt_oe_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
`ifdef PS2_HOST_TX_WATCHDOG_EN
            wd_r     <= {WW{1'b0}};
`endif
        end else begin
            state_r  <= state_s;
            byte_r   <= byte_s;
            parity_r <= parity_s;
            idx_r    <= idx_s;
            icnt_r   <= icnt_s;
            ck_oe_r  <= ck_oe_s;
            dt_oe_r  <= dt_oe_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            err_r    <= err_s;
`ifdef PS2_HOST_TX_WATCHDOG_EN
            wd_r     <= wd_s;
`endif
        end
    end

    // Next-state and output logic; nothing moves between ce ticks.
    always_comb begin
        state_s  = state_r;
        byte_s   = byte_r;
        parity_s = parity_r;
        idx_s    = idx_r;
        icnt_s   = icnt_r;
        ck_oe_s  = ck_oe_r;
        dt_oe_s  = dt_oe_r;
        busy_s   = busy_r;
        done_s   = done_r;
        err_s    = err_r;
`ifdef PS2_HOST_TX_WATCHDOG_EN
        wd_s     = wd_r;
`endif
        if (ce) begin
            done_s = 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (tx) begin
                        byte_s   = d;
                        parity_s = odd_parity(d);
                        busy_s   = 1'b1;
                        ck_oe_s  = 1'b1;
                        dt_oe_s  = 1'b0;
                        err_s    = 1'b0;
                        icnt_s   = {IW{1'b0}};
                        state_s  = ST_INHIBIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                // Device clock falls here come from our own inhibit; ignored.
                ST_INHIBIT: begin
                    if (icnt_r == INH_LAST) begin
                        dt_oe_s = 1'b1;
                        state_s = ST_RTS;
                    end else begin
                        icnt_s = icnt_r + IW'(1);
                    end
                end
                ST_RTS: begin
                    ck_oe_s = 1'b0;
                    idx_s   = 4'd0;
                    state_s = ST_SEND;
`ifdef PS2_HOST_TX_WATCHDOG_EN
                    wd_s    = {WW{1'b0}};
`endif
                end
                ST_SEND: begin
                    if (fall_s) begin
                        case (idx_r)
                            4'd8:    dt_oe_s = ~parity_r;
                            4'd9:    dt_oe_s = 1'b0;
                            4'd10: begin
                                err_s   = data_s;
                                state_s = ST_WAITIDLE;
                            end
                            default: dt_oe_s = ~byte_r[idx_r[2:0]];
                        endcase
                        if (idx_r < 4'd10) begin
                            idx_s = idx_r + 4'd1;
                        end else begin
                            idx_s = idx_r;
                        end
                    end else begin
                        idx_s = idx_r;
                    end
                end
                ST_WAITIDLE: begin
                    if (filt_clk_r && data_s) begin
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_WAITIDLE;
                    end
                end
                default: begin
                    ck_oe_s = 1'b0;
                    dt_oe_s = 1'b0;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end
            endcase
`ifdef PS2_HOST_TX_WATCHDOG_EN
            // Watchdog restarts on every device clock fall.
            if (state_r == ST_SEND || state_r == ST_WAITIDLE) begin
                if (fall_s) begin
                    wd_s = {WW{1'b0}};
                end else if (wd_r == WD_LAST) begin
                    ck_oe_s = 1'b0;
                    dt_oe_s = 1'b0;
                    done_s  = 1'b1;
                    err_s   = 1'b1;
                    busy_s  = 1'b0;
                    state_s = ST_IDLE;
                end else begin
                    wd_s = wd_r + WW'(1);
                end
            end else begin
                wd_s = wd_r;
            end
`endif
        end else begin
            done_s = done_r;
        end
    end

    assign ckOe = ck_oe_r;
    assign dtOe = dt_oe_r;
    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed testbench for ps2_host_tx with a simple PS/2 device model.
module tb_ps2_host_tx;

    localparam int TIMEOUT_C = 3000;

    logic       clock;
    logic       reset;
    logic       ce;
    logic [1:0] ps2;
    logic       tx;
    logic [7:0] d;
    logic       ckOe, dtOe, busy, done, err;
    logic       dev_clk, dev_data;
    logic       clk_line, data_line;

    int n_checks = 0;
    int n_errors = 0;

    // Open-drain bus: either side can pull a line low.
    assign clk_line  = dev_clk & ~ckOe;
    assign data_line = dev_data & ~dtOe;
    assign ps2       = {data_line, clk_line};

    ps2_host_tx #(
        .INHIBIT (700),
        .FILTER  (8),
        .TIMEOUT (TIMEOUT_C)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ce    (ce),
        .ps2   (ps2),
        .tx    (tx),
        .d     (d),
        .ckOe  (ckOe),
        .dtOe  (dtOe),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Request a transfer and time the inhibit / request-to-send phases.
    task automatic start_tx(input logic [7:0] b);
        int cnt;
        @(negedge clock);
        tx = 1'b1;
        d  = b;
        @(negedge clock);
        tx = 1'b0;
        check_eq("busy_after_tx", {31'd0, busy}, 32'd1);
        cnt = 0;
        while (ckOe === 1'b1 && dtOe === 1'b0 && cnt < 2000) begin
            cnt++;
            @(negedge clock);
        end
        check_eq("inhibit_ticks", cnt, 32'd700);
        cnt = 0;
        while (ckOe === 1'b1 && dtOe === 1'b1 && cnt < 10) begin
            cnt++;
            @(negedge clock);
        end
        check_eq("rts_ticks", cnt, 32'd1);
        check_eq("start_ckoe", {31'd0, ckOe}, 32'd0);
        check_eq("start_line", {31'd0, data_line}, 32'd0);
        repeat (30) @(negedge clock);
    endtask

    // One device clock period; the line is sampled while the clock is high.
    task automatic dev_pulse(output logic sample);
        dev_clk = 1'b0;
        repeat (40) @(negedge clock);
        dev_clk = 1'b1;
        repeat (20) @(negedge clock);
        sample = data_line;
        repeat (20) @(negedge clock);
    endtask

    // Clock out a whole frame, optionally acknowledge, then check the end.
    task automatic finish_frame(input logic [7:0] b, input logic par, input logic ack,
                                input logic exp_err);
        logic [9:0] bits;
        logic       s;
        int         cnt;
        for (int i = 0; i < 10; i++) begin
            dev_pulse(s);
            bits[i] = s;
        end
        check_eq("data_bits", {24'd0, bits[7:0]}, {24'd0, b});
        check_eq("parity_bit", {31'd0, bits[8]}, {31'd0, par});
        check_eq("stop_bit", {31'd0, bits[9]}, 32'd1);
        dev_data = ack ? 1'b0 : 1'b1;
        dev_clk  = 1'b0;
        repeat (40) @(negedge clock);
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        cnt = 0;
        while (done !== 1'b1 && cnt < 200) begin
            cnt++;
            @(negedge clock);
        end
        check_eq("done_seen", {31'd0, done}, 32'd1);
        check_eq("err_value", {31'd0, err}, {31'd0, exp_err});
        check_eq("end_ckoe", {31'd0, ckOe}, 32'd0);
        check_eq("end_dtoe", {31'd0, dtOe}, 32'd0);
        check_eq("end_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        check_eq("done_pulse", {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic s;
        int   cnt;
        reset    = 1'b0;
        ce       = 1'b1;
        tx       = 1'b0;
        d        = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (3) @(negedge clock);
        check_eq("rst_ckoe", {31'd0, ckOe}, 32'd0);
        check_eq("rst_dtoe", {31'd0, dtOe}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clock);

        // 0xED: bits 1,0,1,1,0,1,1,1, parity 1.
        start_tx(8'hED);
        finish_frame(8'hED, 1'b1, 1'b1, 1'b0);
        start_tx(8'h00);
        finish_frame(8'h00, 1'b1, 1'b1, 1'b0);
        start_tx(8'h01);
        finish_frame(8'h01, 1'b0, 1'b1, 1'b0);
        // Device does not acknowledge.
        start_tx(8'hFF);
        finish_frame(8'hFF, 1'b1, 1'b0, 1'b1);

        // Reset in the middle of SEND, after the 6th fall (bit 5 on the line).
        start_tx(8'h5A);
        for (int i = 0; i < 6; i++) begin
            dev_pulse(s);
        end
        check_eq("mid_busy", {31'd0, busy}, 32'd1);
        check_eq("mid_bit5_dtoe", {31'd0, dtOe}, 32'd1);
        reset = 1'b0;
        @(negedge clock);
        check_eq("mid_rst_ckoe", {31'd0, ckOe}, 32'd0);
        check_eq("mid_rst_dtoe", {31'd0, dtOe}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clock);
        start_tx(8'h01);
        finish_frame(8'h01, 1'b0, 1'b1, 1'b0);

        // Device stops after 4 clocks.
        start_tx(8'hF3);
        for (int i = 0; i < 4; i++) begin
            dev_pulse(s);
        end
`ifdef PS2_HOST_TX_WATCHDOG_EN
        cnt = 0;
        while (done !== 1'b1 && cnt < TIMEOUT_C + 500) begin
            cnt++;
            @(negedge clock);
        end
        check_eq("wd_done", {31'd0, done}, 32'd1);
        check_eq("wd_err", {31'd0, err}, 32'd1);
        check_eq("wd_ckoe", {31'd0, ckOe}, 32'd0);
        check_eq("wd_dtoe", {31'd0, dtOe}, 32'd0);
        check_eq("wd_busy", {31'd0, busy}, 32'd0);
`else
        cnt = 0;
        repeat (TIMEOUT_C + 500) @(negedge clock);
        check_eq("stall_busy", {31'd0, busy}, 32'd1);
        check_eq("stall_ckoe", {31'd0, ckOe}, 32'd0);
        check_eq("stall_dtoe", {31'd0, dtOe}, 32'd1);
        check_eq("stall_done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check_eq("stall_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
`endif
        repeat (10) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
